mcu_pixel_ingest: RTL and testbench

- Front-end data path of the msgpu between the MCU parallel bus and the VGA scan-out.
- Decodes MCU bus transfers into command bytes and 12-bit pixels, and writes pixels sequentially into an on-chip framebuffer.
- Serves registered reads of the framebuffer to the VGA block.
- Also generates the divided PSRAM clock from system_clock.

---
 rtl/mcu_pixel_ingest.sv | 162 ++++++++++++++++
 tb/tb_mcu_pixel_ingest.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_pixel_ingest.sv
// MCU parallel-bus front end: synchronises the MCU strobe, decodes command and
// pixel bytes, fills the framebuffer sequentially, serves VGA reads and divides the PSRAM clock.
module mcu_pixel_ingest #(
    parameter int PSRAM_DIV  = 3,
    parameter int FB_DEPTH   = 4096,
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  system_clock,
    input  logic                  reset,
    input  logic                  mcu_bus_clock,
    input  logic [7:0]            mcu_bus,
    input  logic                  mcu_bus_command_data,
    output logic                  mcu_command_clock,
    output logic [7:0]            command_byte,
    output logic                  mcu_pixel_clock,
    output logic [11:0]           pixel_data,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    input  logic [ADDR_WIDTH-1:0] framebuffer_read_pointer,
    output logic [11:0]           read_data,
    output logic                  psram_clock
);
    localparam int MEM_AW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CNT_W  = $clog2(PSRAM_DIV);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(FB_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(PSRAM_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_HALF   = CNT_W'(PSRAM_DIV / 2);

    typedef enum logic {PH_BYTE0 = 1'b0, PH_BYTE1 = 1'b1} phase_t;

    logic                  sync1_q, sync2_q, sync3_q;
    logic                  sync1_d, sync2_d, sync3_d;
    phase_t                phase_q, phase_d;
    logic [7:0]            hold_q, hold_d;
    logic [7:0]            command_byte_q, command_byte_d;
    logic                  cmd_pulse_q, cmd_pulse_d;
    logic [11:0]           pixel_q, pixel_d;
    logic                  pix_pulse_q, pix_pulse_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [11:0]           read_data_q, read_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  psram_q, psram_d;
    logic                  strobe_rise_s;
    logic                  mem_we_s;
    logic [11:0]           mem_wdata_s;
    logic [11:0]           mem_q [FB_DEPTH];

    // Next-state logic: strobe edge detection, byte decode, pointer, read mux and divider.
    always_comb begin
        sync1_d        = mcu_bus_clock;
        sync2_d        = sync1_q;
        sync3_d        = sync2_q;
        strobe_rise_s  = sync2_q & ~sync3_q;
        phase_d        = phase_q;
        hold_d         = hold_q;
        command_byte_d = command_byte_q;
        cmd_pulse_d    = 1'b0;
        pixel_d        = pixel_q;
        pix_pulse_d    = 1'b0;
        wp_d           = wp_q;
        mem_we_s       = 1'b0;
        mem_wdata_s    = {hold_q, mcu_bus[3:0]};

        if (strobe_rise_s) begin
            if (mcu_bus_command_data) begin
                command_byte_d = mcu_bus;
                cmd_pulse_d    = 1'b1;
                phase_d        = PH_BYTE0;
                if (mcu_bus == 8'h01) begin
                    wp_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    wp_d = wp_q;
                end
            end else begin
                case (phase_q)
                    PH_BYTE0: begin
                        hold_d  = mcu_bus;
                        phase_d = PH_BYTE1;
                    end
                    PH_BYTE1: begin
                        pixel_d     = mem_wdata_s;
                        pix_pulse_d = 1'b1;
                        mem_we_s    = ~reset;
                        phase_d     = PH_BYTE0;
                        if (wp_q == LAST_ADDR) begin
                            wp_d = {ADDR_WIDTH{1'b0}};
                        end else begin
                            wp_d = wp_q + ADDR_WIDTH'(1);
                        end
                    end
                    default: begin
                        phase_d = PH_BYTE0;
                    end
                endcase
            end
        end else begin
            phase_d = phase_q;
        end

        // Out-of-range read addresses return zero instead of aliasing.
        if (framebuffer_read_pointer < DEPTH_ADDR) begin
            read_data_d = mem_q[framebuffer_read_pointer[MEM_AW-1:0]];
        end else begin
            read_data_d = 12'h000;
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        psram_d = (cnt_q < CNT_HALF);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            phase_q        <= PH_BYTE0;
            hold_q         <= 8'h00;
            command_byte_q <= 8'h00;
            cmd_pulse_q    <= 1'b0;
            pixel_q        <= 12'h000;
            pix_pulse_q    <= 1'b0;
            wp_q           <= {ADDR_WIDTH{1'b0}};
            read_data_q    <= 12'h000;
            cnt_q          <= {CNT_W{1'b0}};
            psram_q        <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            phase_q        <= phase_d;
            hold_q         <= hold_d;
            command_byte_q <= command_byte_d;
            cmd_pulse_q    <= cmd_pulse_d;
            pixel_q        <= pixel_d;
            pix_pulse_q    <= pix_pulse_d;
            wp_q           <= wp_d;
            read_data_q    <= read_data_d;
            cnt_q          <= cnt_d;
            psram_q        <= psram_d;
        end
    end

    // Framebuffer storage; contents deliberately survive reset.
    always_ff @(posedge system_clock) begin
        if (mem_we_s) begin
            mem_q[wp_q[MEM_AW-1:0]] <= mem_wdata_s;
        end
    end

    assign mcu_command_clock = cmd_pulse_q;
    assign command_byte      = command_byte_q;
    assign mcu_pixel_clock   = pix_pulse_q;
    assign pixel_data        = pixel_q;
    assign write_pointer     = wp_q;
    assign read_data         = read_data_q;
    assign psram_clock       = psram_q;
endmodule

// File: tb/tb_mcu_pixel_ingest.sv
// Randomised bench for mcu_pixel_ingest: a transfer-level model predicts every
// output each cycle, plus directed literal checks from the test plan.
module tb_mcu_pixel_ingest;
    localparam int FB = 64;
    localparam int DIV = 3;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mcu_bus_clock = 1'b0;
    logic [7:0]    mcu_bus = 8'h00;
    logic          mcu_bus_command_data = 1'b0;
    logic          mcu_command_clock;
    logic [7:0]    command_byte;
    logic          mcu_pixel_clock;
    logic [11:0]   pixel_data;
    logic [AW-1:0] write_pointer;
    logic [AW-1:0] framebuffer_read_pointer = '0;
    logic [11:0]   read_data;
    logic          psram_clock;

    mcu_pixel_ingest #(.PSRAM_DIV(DIV), .FB_DEPTH(FB), .ADDR_WIDTH(AW)) dut (
        .system_clock(clk), .reset(reset), .mcu_bus_clock(mcu_bus_clock),
        .mcu_bus(mcu_bus), .mcu_bus_command_data(mcu_bus_command_data),
        .mcu_command_clock(mcu_command_clock), .command_byte(command_byte),
        .mcu_pixel_clock(mcu_pixel_clock), .pixel_data(pixel_data),
        .write_pointer(write_pointer),
        .framebuffer_read_pointer(framebuffer_read_pointer),
        .read_data(read_data), .psram_clock(psram_clock)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] b; logic cd; int due;} xfer_t;
    xfer_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_pulses = 0;
    int pix_pulses = 0;

    // model state
    logic [11:0] mem_m [FB];
    bit          written [FB];
    int          m_wp = 0;
    int          m_phase = 0;
    logic [7:0]  m_hold = 8'h00;
    logic [7:0]  m_cmd = 8'h00;
    logic [11:0] m_pix = 12'h000;
    int          run_edges = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle model update and comparison, sampled 1 time unit after each rising edge.
    initial begin
        xfer_t t;
        int addr;
        bit rd_chk;
        logic [11:0] e_rd;
        bit e_cmdp, e_pixp, e_ps;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            e_cmdp = 1'b0;
            e_pixp = 1'b0;
            e_rd = 12'h000;
            rd_chk = 1'b0;
            if (reset) begin
                m_wp = 0; m_phase = 0; m_hold = 8'h00; m_cmd = 8'h00; m_pix = 12'h000;
                q.delete();
                run_edges = 0;
                rd_chk = 1'b1;
            end else begin
                run_edges++;
                addr = int'(framebuffer_read_pointer);
                if (addr >= FB) begin
                    rd_chk = 1'b1;
                end else if (written[addr]) begin
                    rd_chk = 1'b1;
                    e_rd = mem_m[addr];
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    t = q.pop_front();
                    if (t.cd) begin
                        m_cmd = t.b;
                        e_cmdp = 1'b1;
                        m_phase = 0;
                        if (t.b == 8'h01) m_wp = 0;
                    end else if (m_phase == 0) begin
                        m_hold = t.b;
                        m_phase = 1;
                    end else begin
                        m_pix = {m_hold, t.b[3:0]};
                        mem_m[m_wp] = m_pix;
                        written[m_wp] = 1'b1;
                        m_wp = (m_wp + 1) % FB;
                        e_pixp = 1'b1;
                        m_phase = 0;
                    end
                end
            end
            e_ps = (run_edges > 0) && (((run_edges - 1) % DIV) < (DIV / 2));
            chk("cmd_pulse", {31'd0, mcu_command_clock}, {31'd0, e_cmdp});
            chk("pix_pulse", {31'd0, mcu_pixel_clock}, {31'd0, e_pixp});
            chk("command_byte", {24'd0, command_byte}, {24'd0, m_cmd});
            chk("pixel_data", {20'd0, pixel_data}, {20'd0, m_pix});
            chk("write_pointer", 32'(write_pointer), 32'(m_wp));
            chk("psram_clock", {31'd0, psram_clock}, {31'd0, e_ps});
            if (rd_chk) chk("read_data", {20'd0, read_data}, {20'd0, e_rd});
            if (mcu_command_clock === 1'b1) cmd_pulses++;
            if (mcu_pixel_clock === 1'b1) pix_pulses++;
        end
    end

    task automatic xfer(input logic cd, input logic [7:0] b, input int hi, input int lo);
        xfer_t t;
        @(negedge clk);
        mcu_bus = b;
        mcu_bus_command_data = cd;
        mcu_bus_clock = 1'b1;
        t.b = b; t.cd = cd; t.due = cyc + 3;
        q.push_back(t);
        repeat (hi) @(negedge clk);
        mcu_bus_clock = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pixel(input logic [11:0] p);
        xfer(1'b0, p[11:4], 4, 3);
        xfer(1'b0, {4'($urandom_range(15, 0)), p[3:0]}, 4, 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int c0, p0;
        logic [31:0] ps_seen;
        logic [5:0] ps_exp;
        ps_exp = 6'b100100;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            ps_seen = {31'd0, psram_clock};
            chk("psram_pattern", ps_seen, {31'd0, ps_exp[5 - i]});
        end
        chk("reset_wp", 32'(write_pointer), 32'd0);

        // command path
        c0 = cmd_pulses;
        xfer(1'b1, 8'h02, 4, 3);
        chk("cmd02_pulses", 32'(cmd_pulses - c0), 32'd1);
        chk("cmd02_byte", {24'd0, command_byte}, 32'h02);
        chk("cmd02_wp", 32'(write_pointer), 32'd0);

        // pixel path
        p0 = pix_pulses;
        xfer(1'b0, 8'hAB, 4, 3);
        xfer(1'b0, 8'hFC, 4, 3);
        chk("abc_pulses", 32'(pix_pulses - p0), 32'd1);
        chk("abc_pixel", {20'd0, pixel_data}, 32'hABC);
        chk("abc_wp", 32'(write_pointer), 32'd1);
        @(negedge clk);
        framebuffer_read_pointer = '0;
        repeat (2) @(negedge clk);
        chk("abc_read", {20'd0, read_data}, 32'hABC);

        // a command between data bytes restarts byte phase
        p0 = pix_pulses;
        xfer(1'b0, 8'h12, 4, 3);
        xfer(1'b1, 8'h05, 4, 3);
        xfer(1'b0, 8'h34, 4, 3);
        xfer(1'b0, 8'h56, 4, 3);
        chk("phase_pulses", 32'(pix_pulses - p0), 32'd1);
        chk("phase_pixel", {20'd0, pixel_data}, 32'h346);
        xfer(1'b1, 8'h01, 4, 3);
        chk("cmd01_wp", 32'(write_pointer), 32'd0);

        // reset discards a half-received pixel
        xfer(1'b0, 8'h77, 4, 3);
        do_reset();
        xfer(1'b0, 8'h9D, 4, 3);
        xfer(1'b0, 8'h2E, 4, 3);
        chk("rst_phase_pixel", {20'd0, pixel_data}, 32'h9DE);
        chk("rst_phase_wp", 32'(write_pointer), 32'd1);

        // wrap: FB+1 pixels from address 0
        xfer(1'b1, 8'h01, 4, 3);
        for (int k = 0; k <= FB; k++) pixel(12'(k * 37 + 5));
        chk("wrap_wp", 32'(write_pointer), 32'd1);
        @(negedge clk);
        framebuffer_read_pointer = '0;
        repeat (2) @(negedge clk);
        chk("wrap_mem0", {20'd0, read_data}, 32'h945);
        framebuffer_read_pointer = AW'(FB);
        repeat (2) @(negedge clk);
        chk("oob_read", {20'd0, read_data}, 32'h000);

        // held strobe fires once
        c0 = cmd_pulses;
        xfer(1'b1, 8'h3C, 20, 3);
        chk("held_pulses", 32'(cmd_pulses - c0), 32'd1);

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            logic cd;
            logic [7:0] b;
            cd = ($urandom_range(3, 0) == 0);
            b = 8'($urandom);
            if (cd && $urandom_range(4, 0) == 0) b = 8'h01;
            framebuffer_read_pointer = AW'($urandom_range(FB + 3, 0));
            xfer(cd, b, $urandom_range(8, 4), $urandom_range(5, 3));
        end
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
